// File: rtl/fetch_defs.sv
// Shared fetch-stage definitions: FSM state encoding, instruction width, PC step
// and the branch opcode shared with the immediate generator.
package fetch_defs;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select (redirect target / pc+4 / hold) with misalignment
// detect. FETCH_MISALIGN_TRAP_EN keeps raw target bits and flags misalignment.
module fetch_pc_next
  import fetch_defs::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic            take_redirect,
  input  logic            advance,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_imm,
  output logic [XLEN-1:0] pc_next,
  output logic            target_misaligned
);

  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;

  assign target_raw = redirect_base + redirect_imm;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target            = target_raw;
  assign target_misaligned = take_redirect && (target_raw[1:0] != 2'b00);
`else
  // Without the trap, a misaligned target is silently word-aligned.
  assign target            = target_raw & ~XLEN'(3);
  assign target_misaligned = 1'b0;
`endif

  always_comb begin
    pc_next = pc;
    if (take_redirect) begin
      pc_next = target;
    end else if (advance) begin
      pc_next = pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding imem request, response drop after redirect,
// decode handshake. Misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
  import fetch_defs::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_base,
  input  logic [XLEN-1:0]   redirect_imm,
  output logic              fetch_misaligned
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              drop_q, drop_d;
  logic              misaligned_q, misaligned_d;

  logic              take_redirect;
  logic              advance;
  logic [XLEN-1:0]   pc_next;
  logic              trap;

  assign take_redirect = redirect_valid && (state_q != FS_IDLE);
  assign advance       = (state_q == FS_HOLD) && inst_ready;

  fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc                (pc_q),
    .take_redirect     (take_redirect),
    .advance           (advance),
    .redirect_base     (redirect_base),
    .redirect_imm      (redirect_imm),
    .pc_next           (pc_next),
    .target_misaligned (trap)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_next;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    drop_d       = drop_q;
    misaligned_d = misaligned_q;

    case (state_q)
      FS_IDLE: begin
        if (!misaligned_q) state_d = FS_REQ;
      end
      FS_REQ: begin
        if (imem_req_ready) begin
          state_d = FS_WAIT;
          drop_d  = take_redirect;
        end
      end
      FS_WAIT: begin
        if (take_redirect) begin
          if (imem_rsp_valid) begin
            state_d = FS_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            state_d = FS_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d   = FS_HOLD;
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
          end
        end
      end
      FS_HOLD: begin
        if (take_redirect || inst_ready) state_d = FS_REQ;
      end
      default: state_d = FS_IDLE;
    endcase

    // A misaligned redirect parks the stage until reset; in-flight data is abandoned.
    if (trap) begin
      state_d      = FS_IDLE;
      pc_d         = pc_q;
      drop_d       = 1'b0;
      misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      drop_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      drop_q       <= drop_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req_valid   = (state_q == FS_REQ);
  assign imem_req_addr    = pc_q;
  assign inst_valid       = (state_q == FS_HOLD);
  assign inst             = inst_q;
  assign inst_pc          = inst_pc_q;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; a second instance checks PC wrap from a
// high RESET_PC. Misalignment expectations follow FETCH_MISALIGN_TRAP_EN.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_base;
  logic [63:0] redirect_imm;

  logic        req_valid_a, inst_valid_a, mis_a;
  logic [63:0] req_addr_a, inst_pc_a;
  logic [31:0] inst_a;
  logic        req_valid_b, inst_valid_b, mis_b;
  logic [63:0] req_addr_b, inst_pc_b;
  logic [31:0] inst_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_a),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready), .inst(inst_a), .inst_pc(inst_pc_a),
    .redirect_valid(redirect_valid), .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .fetch_misaligned(mis_a)
  );

  instruction_fetch #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_b),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready), .inst(inst_b), .inst_pc(inst_pc_b),
    .redirect_valid(redirect_valid), .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .fetch_misaligned(mis_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_base  = 64'h0;
    redirect_imm   = 64'h0;
  endtask

  // Leaves both DUTs in IDLE with rst low; the next edge moves them to REQ.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (req_valid_a !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid_a); end
    checks++; if (inst_valid_a !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%0b exp=0", inst_valid_a); end
    checks++; if (req_addr_a !== 64'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", req_addr_a); end
    checks++; if (inst_a !== 32'h0 || inst_pc_a !== 64'h0) begin errors++; $display("FAIL reset_inst got=%h/%h exp=0/0", inst_a, inst_pc_a); end
    checks++; if (mis_a !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%0b exp=0", mis_a); end
    checks++; if (req_addr_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL reset_addr_wrapdut got=%h exp=fffffffffffffffc", req_addr_b); end
  endtask

  task automatic test_sequential();
    logic [31:0] word;
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      word = 32'hC0DE_0000 + 32'(i);
      checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 64'(4 * i)) begin errors++; $display("FAIL seq_req%0d got=%0b/%h exp=1/%h", i, req_valid_a, req_addr_a, 64'(4 * i)); end
      checks++; if (inst_valid_a !== 1'b0) begin errors++; $display("FAIL seq_no_inst_before%0d got=%0b exp=0", i, inst_valid_a); end
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      tick();
      imem_rsp_valid = 1'b0;
      checks++; if (inst_valid_a !== 1'b1 || inst_a !== word || inst_pc_a !== 64'(4 * i)) begin errors++; $display("FAIL seq_inst%0d got=%0b/%h/%h exp=1/%h/%h", i, inst_valid_a, inst_a, inst_pc_a, word, 64'(4 * i)); end
      tick();
    end
  endtask

  task automatic test_decode_stall();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222;
    inst_ready = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid_a !== 1'b1 || inst_a !== 32'h2222_2222 || inst_pc_a !== 64'h4 || req_valid_a !== 1'b0 || req_addr_a !== 64'h4) begin
        errors++; $display("FAIL stall_hold%0d got=%0b/%h/%h/%0b/%h exp=1/22222222/4/0/4", i, inst_valid_a, inst_a, inst_pc_a, req_valid_a, req_addr_a);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 64'h8 || inst_valid_a !== 1'b0) begin errors++; $display("FAIL stall_release got=%0b/%h/%0b exp=1/8/0", req_valid_a, req_addr_a, inst_valid_a); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_base  = 64'h10;
    redirect_imm   = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b0 || req_addr_a !== 64'h8) begin errors++; $display("FAIL rdw_wait got=%0b/%h exp=0/8", req_valid_a, req_addr_a); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0014;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid_a !== 1'b0 || req_valid_a !== 1'b1 || req_addr_a !== 64'h8) begin errors++; $display("FAIL rdw_drop got=%0b/%0b/%h exp=0/1/8", inst_valid_a, req_valid_a, req_addr_a); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0808;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid_a !== 1'b1 || inst_a !== 32'h0000_0808 || inst_pc_a !== 64'h8) begin errors++; $display("FAIL rdw_refetch got=%0b/%h/%h exp=1/00000808/8", inst_valid_a, inst_a, inst_pc_a); end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_base = 64'h40; redirect_imm = 64'h10;
    tick();
    checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 64'h50) begin errors++; $display("FAIL rdc_req_nohs got=%0b/%h exp=1/50", req_valid_a, req_addr_a); end
    imem_req_ready = 1'b1;
    redirect_base = 64'h100; redirect_imm = 64'h20;
    tick();
    redirect_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b0 || req_addr_a !== 64'h120) begin errors++; $display("FAIL rdc_req_hs got=%0b/%h exp=0/120", req_valid_a, req_addr_a); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0050;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid_a !== 1'b0 || req_valid_a !== 1'b1 || req_addr_a !== 64'h120) begin errors++; $display("FAIL rdc_stale_drop got=%0b/%0b/%h exp=0/1/120", inst_valid_a, req_valid_a, req_addr_a); end
    tick();
    checks++; if (req_valid_a !== 1'b0) begin errors++; $display("FAIL rdc_single_req got=%0b exp=0", req_valid_a); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0120;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid_a !== 1'b1 || inst_a !== 32'h0000_0120 || inst_pc_a !== 64'h120) begin errors++; $display("FAIL rdc_target_inst got=%0b/%h/%h exp=1/00000120/120", inst_valid_a, inst_a, inst_pc_a); end
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_base = 64'h200; redirect_imm = 64'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid_a !== 1'b0 || req_valid_a !== 1'b1 || req_addr_a !== 64'h240) begin errors++; $display("FAIL rdc_hold_redirect got=%0b/%0b/%h exp=0/1/240", inst_valid_a, req_valid_a, req_addr_a); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_first got=%0b/%h exp=1/fffffffffffffffc", req_valid_b, req_addr_b); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_FFFC;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid_b !== 1'b1 || inst_pc_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_inst got=%0b/%h exp=1/fffffffffffffffc", inst_valid_b, inst_pc_b); end
    tick();
    checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 64'h0) begin errors++; $display("FAIL wrap_next got=%0b/%h exp=1/0", req_valid_b, req_addr_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h7777_0000;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h7777_0004;
    tick();
    checks++; if (req_valid_a !== 1'b0 || inst_valid_a !== 1'b0 || req_addr_a !== 64'h0 || inst_a !== 32'h0 || inst_pc_a !== 64'h0) begin
      errors++; $display("FAIL midrst_state got=%0b/%0b/%h/%h/%h exp=0/0/0/0/0", req_valid_a, inst_valid_a, req_addr_a, inst_a, inst_pc_a);
    end
    rst = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b1 || inst_valid_a !== 1'b0 || req_addr_a !== 64'h0 || inst_a !== 32'h0) begin errors++; $display("FAIL midrst_late_rsp got=%0b/%0b/%h/%h exp=1/0/0/0", req_valid_a, inst_valid_a, req_addr_a, inst_a); end
  endtask

  task automatic test_misalign();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_base = 64'h2; redirect_imm = 64'h4;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (mis_a !== 1'b1 || req_valid_a !== 1'b0) begin errors++; $display("FAIL mis_trap got=%0b/%0b exp=1/0", mis_a, req_valid_a); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h6666_6666;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mis_a !== 1'b1 || req_valid_a !== 1'b0 || inst_valid_a !== 1'b0) begin errors++; $display("FAIL mis_parked%0d got=%0b/%0b/%0b exp=1/0/0", i, mis_a, req_valid_a, inst_valid_a); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mis_a !== 1'b0) begin errors++; $display("FAIL mis_clear got=%0b exp=0", mis_a); end
`else
    checks++; if (mis_a !== 1'b0 || req_valid_a !== 1'b0 || req_addr_a !== 64'h4) begin errors++; $display("FAIL mis_align got=%0b/%0b/%h exp=0/0/4", mis_a, req_valid_a, req_addr_a); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h6666_6666;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b1 || req_addr_a !== 64'h4 || inst_valid_a !== 1'b0) begin errors++; $display("FAIL mis_next_req got=%0b/%h/%0b exp=1/4/0", req_valid_a, req_addr_a, inst_valid_a); end
`endif
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_sequential();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
